muldiv_ctrl_seq: RTL and testbench
==================================

Name: muldiv_ctrl_seq

Overview:
- Hardwired control sequencer for the CPU datapath.
- Fetches an instruction (PC→MAR, memory read into MDR, MDR→IR), then decodes MUL or DIV from IR.
- Executes the operation as: Y←Rb; Z←Y op Rc; LO←Zlow; HI←Zhigh.
- Drives the same one-hot strobes the datapath already consumes and replaces hand-sequenced stimulus for multiply/divide instructions.

Parameters:
- OP_MUL, 5'b01111, IR[31:27] opcode value for MUL.
- OP_DIV, 5'b10000, IR[31:27] opcode value for DIV.
- DIV_LATENCY, 4, cycles the datapath divider needs with operands stable (1..15).

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  asynchronous active-high reset
- run  input  1  level; high = keep fetching/executing
- IR  input  32  instruction register contents
- mem_ready  input  1  memory read data valid this cycle
- div_zero  input  1  divisor on bus is zero (used only with optional feature)
- PCout, Zlowout, Zhighout, MDRout  output  1 each  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin  output  1 each  register load strobes
- IncPC, Read, MUL, DIV  output  1 each  ALU/memory controls
- Rout  output  1  general register drives bus
- Rsel  output  4  general register index for Rout
- busy  output  1  high in every state except IDLE and ILLEGAL
- done  output  1  one-cycle pulse on instruction completion
- illegal  output  1  sticky: unsupported opcode decoded
- div_err  output  1  one-cycle pulse on divide-by-zero trap

Behaviour:
- Reset: async on clr. State goes to IDLE, all outputs 0, illegal cleared, divide counter 0. Reset mid-instruction aborts immediately; no strobe glitches high.
- Outputs are Moore, decoded from the registered state (plus the divide counter). Each strobe is asserted for the whole cycle its state is occupied.
- IDLE: no strobes. Go to T0 when run=1.
- T0: PCout, MARin, IncPC, Zin. Next: T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0.
  - PCin asserts only in the first T1 cycle; Read and MDRin are held for the whole wait.
  - Go to T2 on the cycle mem_ready=1.
- T2: MDRout, IRin. Next: T3.
- T3: decode IR[31:27].
  - MUL or DIV: assert Rout with Rsel=IR[22:19] (Rb), and Yin. Next: T4.
  - Any other opcode: no strobes. Next: ILLEGAL.
- T4: Rout with Rsel=IR[18:15] (Rc).
  - MUL: MUL and Zin asserted for 1 cycle.
  - DIV: DIV and Rout held for DIV_LATENCY cycles; Zin asserted on the last of those cycles only.
  - Next: T5.
- T5: Zlowout, LOin. Next: T6.
- T6: Zhighout, HIin, done. Next: T0 if run=1, else IDLE.
- ILLEGAL: illegal=1, no strobes, busy=0. Exit only via clr.
- Latency with mem_ready tied high: MUL takes 7 cycles from T0 entry to done; DIV takes 6+DIV_LATENCY.
- run is sampled only in IDLE and T6. Deasserting run mid-instruction does not abort it.
- Rsel is 0 whenever Rout=0.
- At most one bus-drive strobe is high in any cycle (PCout, Zlowout, Zhighout, MDRout, Rout).

Optional Feature:
- Macro: MULDIV_DIV_ZERO_TRAP_EN.
- Defined:
  - div_zero is sampled in the first T4 cycle of a DIV.
  - If div_zero=1, go to TRAP instead of continuing: Zin, LOin, HIin are never asserted.
  - TRAP lasts 1 cycle: div_err=1, done=1. Then T0 if run=1, else IDLE.
  - LO and HI keep their previous values.
- Undefined: div_zero is ignored, the TRAP state does not exist, and div_err is tied 0.

Test Plan:
- MUL, R4=2, R5=-10, IR opcode OP_MUL with Rb=4, Rc=5, mem_ready=1 -> strobe sequence T0..T6 exactly as specified; LO=0xFFFFFFEC, HI=0xFFFFFFFF; done high in cycle 7.
- DIV, R4=2, R5=-10, DIV_LATENCY=4 -> DIV held 4 cycles, Zin only in the 4th; LO=0 (quotient), HI=2 (remainder); done in cycle 10.
- mem_ready low for 3 cycles in T1 -> T1 lasts 4 cycles; PCin high in the first only; Read/MDRin high throughout; IRin loads correct word.
- IR opcode 5'b00101 -> ILLEGAL after T3; illegal=1, busy=0, no further strobes; clr clears illegal and returns to IDLE.
- clr pulsed during DIV T4 cycle 2 -> all strobes 0 within the same cycle, state IDLE, LOin/HIin never asserted.
- With MULDIV_DIV_ZERO_TRAP_EN, DIV with R5=0, div_zero=1 -> div_err and done pulse one cycle after T4 entry; LO/HI unchanged. Without the macro: normal 4-cycle DIV sequence, div_err=0.

Source files
------------

// File: rtl/muldiv_ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer driving datapath strobes for MUL and DIV.
// Define MULDIV_DIV_ZERO_TRAP_EN to trap a DIV whose divisor is zero.
module muldiv_ctrl_seq #(
  parameter logic [4:0]  OP_MUL      = 5'b01111,
  parameter logic [4:0]  OP_DIV      = 5'b10000,
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        div_zero,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic        IncPC,
  output logic        Read,
  output logic        MUL,
  output logic        DIV,
  output logic        Rout,
  output logic [3:0]  Rsel,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        div_err
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StIllegal
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    , StTrap
`endif
  } state_e;

  localparam logic [3:0] DivLast = 4'(DIV_LATENCY - 1);

  state_e     state_q, state_d;
  logic       t1_wait_q, t1_wait_d;
  logic       is_div_q, is_div_d;
  logic [3:0] div_cnt_q, div_cnt_d;

  logic [4:0] opcode;
  logic       op_mul, op_div;
  assign opcode = IR[31:27];
  assign op_mul = (opcode == OP_MUL);
  assign op_div = (opcode == OP_DIV);

  logic unused_sig;
  assign unused_sig = ^{IR[26:23], IR[14:0], div_zero};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      t1_wait_q <= 1'b0;
      is_div_q  <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
      is_div_q  <= is_div_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    div_cnt_d = '0;
    // Marks every T1 cycle after the first so PCin fires only once per fetch.
    t1_wait_d = (state_q == StT1);
    unique case (state_q)
      StIdle: if (run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (mem_ready) state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        if (op_mul || op_div) begin
          state_d  = StT4;
          is_div_d = op_div;
        end else begin
          state_d = StIllegal;
        end
      end
      StT4: begin
        if (!is_div_q) begin
          state_d = StT5;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
        end else if (div_cnt_q == '0 && div_zero) begin
          state_d = StTrap;
`endif
        end else if (div_cnt_q == DivLast) begin
          state_d = StT5;
        end else begin
          div_cnt_d = div_cnt_q + 4'd1;
        end
      end
      StT5:      state_d = StT6;
      StT6:      state_d = run ? StT0 : StIdle;
      StIllegal: state_d = StIllegal;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
      StTrap:    state_d = run ? StT0 : StIdle;
`endif
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    {PCout, Zlowout, Zhighout, MDRout}             = '0;
    {MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin} = '0;
    {IncPC, Read, MUL, DIV, Rout}                  = '0;
    Rsel    = '0;
    done    = 1'b0;
    div_err = 1'b0;
    busy    = (state_q != StIdle) && (state_q != StIllegal);
    illegal = (state_q == StIllegal);
    unique case (state_q)
      StT0: {PCout, MARin, IncPC, Zin} = '1;
      StT1: begin
        {Zlowout, Read, MDRin} = '1;
        PCin = !t1_wait_q;
      end
      StT2: {MDRout, IRin} = '1;
      StT3: begin
        if (op_mul || op_div) begin
          Rout = 1'b1;
          Yin  = 1'b1;
          Rsel = IR[22:19];
        end
      end
      StT4: begin
        Rout = 1'b1;
        Rsel = IR[18:15];
        if (is_div_q) begin
          DIV = 1'b1;
          Zin = (div_cnt_q == DivLast);
`ifdef MULDIV_DIV_ZERO_TRAP_EN
          // A trapped divide must never load Z, even with a one-cycle divider.
          if (div_cnt_q == '0 && div_zero) Zin = 1'b0;
`endif
        end else begin
          MUL = 1'b1;
          Zin = 1'b1;
        end
      end
      StT5: {Zlowout, LOin} = '1;
      StT6: {Zhighout, HIin, done} = '1;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
      StTrap: {div_err, done} = '1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl_seq.sv
// Directed bench for muldiv_ctrl_seq with a small behavioural datapath driven by its strobes.
module tb_muldiv_ctrl_seq;
  localparam int unsigned DivLat = 4;

  localparam logic [20:0] S_PCOUT   = 21'b1 << 20;
  localparam logic [20:0] S_ZLOWOUT = 21'b1 << 19;
  localparam logic [20:0] S_ZHIOUT  = 21'b1 << 18;
  localparam logic [20:0] S_MDROUT  = 21'b1 << 17;
  localparam logic [20:0] S_MARIN   = 21'b1 << 16;
  localparam logic [20:0] S_PCIN    = 21'b1 << 15;
  localparam logic [20:0] S_MDRIN   = 21'b1 << 14;
  localparam logic [20:0] S_IRIN    = 21'b1 << 13;
  localparam logic [20:0] S_YIN     = 21'b1 << 12;
  localparam logic [20:0] S_ZIN     = 21'b1 << 11;
  localparam logic [20:0] S_LOIN    = 21'b1 << 10;
  localparam logic [20:0] S_HIIN    = 21'b1 << 9;
  localparam logic [20:0] S_INCPC   = 21'b1 << 8;
  localparam logic [20:0] S_READ    = 21'b1 << 7;
  localparam logic [20:0] S_MUL     = 21'b1 << 6;
  localparam logic [20:0] S_DIV     = 21'b1 << 5;
  localparam logic [20:0] S_ROUT    = 21'b1 << 4;
  localparam logic [20:0] S_BUSY    = 21'b1 << 3;
  localparam logic [20:0] S_DONE    = 21'b1 << 2;
  localparam logic [20:0] S_ILL     = 21'b1 << 1;
  localparam logic [20:0] S_DIVERR  = 21'b1;

  localparam logic [20:0] E_IDLE = '0;
  localparam logic [20:0] E_T0   = S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_BUSY;
  localparam logic [20:0] E_T1F  = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN | S_BUSY;
  localparam logic [20:0] E_T1W  = S_ZLOWOUT | S_READ | S_MDRIN | S_BUSY;
  localparam logic [20:0] E_T2   = S_MDROUT | S_IRIN | S_BUSY;
  localparam logic [20:0] E_T3   = S_ROUT | S_YIN | S_BUSY;
  localparam logic [20:0] E_T4M  = S_ROUT | S_MUL | S_ZIN | S_BUSY;
  localparam logic [20:0] E_T4D  = S_ROUT | S_DIV | S_BUSY;
  localparam logic [20:0] E_T5   = S_ZLOWOUT | S_LOIN | S_BUSY;
  localparam logic [20:0] E_T6   = S_ZHIOUT | S_HIIN | S_DONE | S_BUSY;
  localparam logic [20:0] E_T3I  = S_BUSY;
  localparam logic [20:0] E_ILL  = S_ILL;
  localparam logic [20:0] E_TRAP = S_DIVERR | S_DONE | S_BUSY;

  logic clk, clr, run, mem_ready, div_zero;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin;
  logic IncPC, Read, MUL, DIV, Rout, busy, done, illegal, div_err;
  logic [3:0] Rsel;

  // Datapath model state
  logic [31:0] mem [8];
  logic [31:0] regs [16];
  logic [31:0] pc = 32'd0, mar = 32'd0, mdr = 32'd0, ir = 32'd0, y = 32'd0;
  logic [31:0] lo = 32'd0, hi = 32'd0;
  logic [63:0] z = 64'd0;
  int          lohi_loads = 0;
  logic [31:0] bus;
  logic signed [63:0] ys, bs;
  logic signed [31:0] quot, rem;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [20:0] s;
    logic [3:0]  rsel;
  } exp_t;
  exp_t exp_q[$];

  logic [20:0] obs;
  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
                IncPC, Read, MUL, DIV, Rout, busy, done, illegal, div_err};

  muldiv_ctrl_seq #(.DIV_LATENCY(DivLat)) dut (
    .clk(clk), .clr(clr), .run(run), .IR(ir), .mem_ready(mem_ready), .div_zero(div_zero),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .MUL(MUL), .DIV(DIV),
    .Rout(Rout), .Rsel(Rsel), .busy(busy), .done(done), .illegal(illegal), .div_err(div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus = PCout ? pc : Zlowout ? z[31:0] : Zhighout ? z[63:32] : MDRout ? mdr :
               Rout ? regs[Rsel] : 32'd0;
  assign div_zero = Rout && (bus == 32'd0);
  assign ys   = $signed(y);
  assign bs   = $signed(bus);
  assign quot = (bus == 32'd0) ? 32'sd0 : $signed(y) / $signed(bus);
  assign rem  = (bus == 32'd0) ? 32'sd0 : $signed(y) % $signed(bus);

  always @(posedge clk) begin
    if (MARin) mar <= bus;
    if (PCin)  pc  <= bus;
    if (IRin)  ir  <= bus;
    if (Yin)   y   <= bus;
    if (LOin)  lo  <= bus;
    if (HIin)  hi  <= bus;
    if (LOin || HIin) lohi_loads <= lohi_loads + 1;
    if (MDRin && Read && mem_ready) mdr <= mem[mar[2:0]];
    if (Zin) begin
      if (IncPC)    z <= {32'd0, bus + 32'd1};
      else if (MUL) z <= ys * bs;
      else if (DIV) z <= {rem, quot};
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rb,
                                     input logic [3:0] rc);
    return {op, 4'd0, rb, rc, 15'd0};
  endfunction

  task automatic push(input logic [20:0] s, input logic [3:0] rsel);
    exp_t e;
    e.s = s;
    e.rsel = rsel;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch(input int waits);
    push(E_T0, 4'd0);
    push(E_T1F, 4'd0);
    for (int k = 0; k < waits; k++) push(E_T1W, 4'd0);
    push(E_T2, 4'd0);
  endtask

  task automatic push_exec(input bit is_div, input logic [3:0] rb, input logic [3:0] rc);
    push(E_T3, rb);
    if (!is_div) push(E_T4M, rc);
    else for (int k = 0; k < int'(DivLat); k++)
      push((k == int'(DivLat) - 1) ? (E_T4D | S_ZIN) : E_T4D, rc);
    push(E_T5, 4'd0);
    push(E_T6, 4'd0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE || Rsel !== 4'd0) begin
      failures++;
      $display("FAIL reset_held: got %h rsel=%0d, want %h rsel=0", obs, Rsel, E_IDLE);
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE || Rsel !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle: got %h rsel=%0d, want %h rsel=0", obs, Rsel, E_IDLE);
    end
  endtask

  task automatic test_mul;
    exp_q.delete();
    push_fetch(0);
    push_exec(1'b0, 4'd4, 4'd5);
    push(E_IDLE, 4'd0);
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b0;
      checks++;
      if (obs !== exp_q[i].s || Rsel !== exp_q[i].rsel) begin
        failures++;
        $display("FAIL mul_seq cycle %0d: got %h rsel=%0d, want %h rsel=%0d",
                 i + 1, obs, Rsel, exp_q[i].s, exp_q[i].rsel);
      end
    end
    checks++;
    if (lo !== 32'hFFFF_FFEC || hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL mul_lohi: got lo=%h hi=%h, want lo=ffffffec hi=ffffffff", lo, hi);
    end
    checks++;
    if (pc !== 32'd1) begin
      failures++;
      $display("FAIL mul_pc: got %0d, want 1", pc);
    end
  endtask

  task automatic test_div;
    exp_q.delete();
    push_fetch(0);
    push_exec(1'b1, 4'd4, 4'd5);
    push(E_IDLE, 4'd0);
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b0;
      checks++;
      if (obs !== exp_q[i].s || Rsel !== exp_q[i].rsel) begin
        failures++;
        $display("FAIL div_seq cycle %0d: got %h rsel=%0d, want %h rsel=%0d",
                 i + 1, obs, Rsel, exp_q[i].s, exp_q[i].rsel);
      end
    end
    checks++;
    if (lo !== 32'd0 || hi !== 32'd2) begin
      failures++;
      $display("FAIL div_lohi: got lo=%h hi=%h, want lo=0 hi=2", lo, hi);
    end
  endtask

  task automatic test_mem_wait;
    exp_q.delete();
    push_fetch(3);
    push_exec(1'b0, 4'd5, 4'd5);
    push(E_IDLE, 4'd0);
    mem_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b0;
      checks++;
      if (obs !== exp_q[i].s || Rsel !== exp_q[i].rsel) begin
        failures++;
        $display("FAIL memwait_seq cycle %0d: got %h rsel=%0d, want %h rsel=%0d",
                 i + 1, obs, Rsel, exp_q[i].s, exp_q[i].rsel);
      end
      if (i == 4) mem_ready = 1'b1;
    end
    checks++;
    if (ir !== mem[2]) begin
      failures++;
      $display("FAIL memwait_ir: got %h, want %h", ir, mem[2]);
    end
    checks++;
    if (lo !== 32'd100 || hi !== 32'd0) begin
      failures++;
      $display("FAIL memwait_lohi: got lo=%0d hi=%0d, want lo=100 hi=0", lo, hi);
    end
  endtask

  task automatic test_illegal;
    exp_q.delete();
    push_fetch(0);
    push(E_T3I, 4'd0);
    for (int k = 0; k < 3; k++) push(E_ILL, 4'd0);
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i].s || Rsel !== exp_q[i].rsel) begin
        failures++;
        $display("FAIL illegal_seq cycle %0d: got %h rsel=%0d, want %h rsel=%0d",
                 i + 1, obs, Rsel, exp_q[i].s, exp_q[i].rsel);
      end
    end
    run = 1'b0;
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL illegal_clr: got %h, want %h", obs, E_IDLE);
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL illegal_after_clr: got %h, want %h", obs, E_IDLE);
    end
  endtask

  task automatic test_clr_mid_div;
    int          loads0;
    logic [31:0] lo0, hi0;
    loads0 = lohi_loads;
    lo0 = lo;
    hi0 = hi;
    exp_q.delete();
    push_fetch(0);
    push(E_T3, 4'd4);
    push(E_T4D, 4'd5);
    push(E_T4D, 4'd5);
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b0;
      checks++;
      if (obs !== exp_q[i].s || Rsel !== exp_q[i].rsel) begin
        failures++;
        $display("FAIL clrdiv_seq cycle %0d: got %h rsel=%0d, want %h rsel=%0d",
                 i + 1, obs, Rsel, exp_q[i].s, exp_q[i].rsel);
      end
    end
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE || Rsel !== 4'd0) begin
      failures++;
      $display("FAIL clrdiv_abort: got %h rsel=%0d, want %h rsel=0", obs, Rsel, E_IDLE);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_IDLE) begin
        failures++;
        $display("FAIL clrdiv_idle cycle %0d: got %h, want %h", i, obs, E_IDLE);
      end
    end
    checks++;
    if (lohi_loads !== loads0 || lo !== lo0 || hi !== hi0) begin
      failures++;
      $display("FAIL clrdiv_lohi: got loads=%0d lo=%h hi=%h, want loads=%0d lo=%h hi=%h",
               lohi_loads, lo, hi, loads0, lo0, hi0);
    end
  endtask

  task automatic test_div_zero;
    int          loads0;
    logic [31:0] lo0, hi0;
    loads0 = lohi_loads;
    lo0 = lo;
    hi0 = hi;
    exp_q.delete();
    push_fetch(0);
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    push(E_T3, 4'd4);
    push(E_T4D, 4'd6);
    push(E_TRAP, 4'd0);
`else
    push_exec(1'b1, 4'd4, 4'd6);
`endif
    push(E_IDLE, 4'd0);
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b0;
      checks++;
      if (obs !== exp_q[i].s || Rsel !== exp_q[i].rsel) begin
        failures++;
        $display("FAIL divzero_seq cycle %0d: got %h rsel=%0d, want %h rsel=%0d",
                 i + 1, obs, Rsel, exp_q[i].s, exp_q[i].rsel);
      end
    end
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    checks++;
    if (lohi_loads !== loads0 || lo !== lo0 || hi !== hi0) begin
      failures++;
      $display("FAIL divzero_lohi: got loads=%0d lo=%h hi=%h, want loads=%0d lo=%h hi=%h",
               lohi_loads, lo, hi, loads0, lo0, hi0);
    end
`else
    checks++;
    if (lohi_loads !== loads0 + 2) begin
      failures++;
      $display("FAIL divzero_loads: got %0d, want %0d", lohi_loads, loads0 + 2);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    regs[4] = 32'd2;
    regs[5] = 32'hFFFF_FFF6;
    regs[6] = 32'd0;
    mem[0] = mk(5'b01111, 4'd4, 4'd5);
    mem[1] = mk(5'b10000, 4'd4, 4'd5);
    mem[2] = mk(5'b01111, 4'd5, 4'd5);
    mem[3] = mk(5'b00101, 4'd4, 4'd5);
    mem[4] = mk(5'b10000, 4'd4, 4'd5);
    mem[5] = mk(5'b10000, 4'd4, 4'd6);
    mem[6] = 32'd0;
    mem[7] = 32'd0;
    clr = 1'b1;
    run = 1'b0;
    mem_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_mem_wait();
    test_illegal();
    test_clr_mid_div();
    test_div_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
